mcp_controller: RTL and testbench

MCP_CONTROLLER -- requirements
Module: mcp_controller

---
 rtl/mcp_controller.sv | 148 ++++++++++++++
 tb/tb_mcp_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcp_controller.sv
// Multicycle MIPS-style main controller: Moore FSM sequencing fetch, decode and
// per-instruction execute/writeback, plus the R-type ALU function decode.
module mcp_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  logic pcwrite, branch;
  logic irwrite_s, memwrite_s, regwrite_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    unique case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        unique case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIWB:  regwrite_s = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset_n directly so they drop the instant reset
  // asserts, independent of the state register's async clear.
  assign pcen     = reset_n & (pcwrite | (branch & zero));
  assign irwrite  = reset_n & irwrite_s;
  assign memwrite = reset_n & memwrite_s;
  assign regwrite = reset_n & regwrite_s;
  assign state    = state_q;

endmodule

// File: tb/tb_mcp_controller.sv
// Directed bench for mcp_controller: walks each instruction class through its
// state sequence and compares state plus all outputs against hand-built vectors.
module tb_mcp_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int compared   = 0;
  int mismatched = 0;

  mcp_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  always #5 clk = ~clk;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol}
  logic [14:0] outs;
  assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, pcsrc, alucontrol};

  localparam logic [14:0] V_RST    = 15'b0000000_0_01_00_010;
  localparam logic [14:0] V_FETCH  = 15'b1001000_0_01_00_010;
  localparam logic [14:0] V_DECODE = 15'b0000000_0_11_00_010;
  localparam logic [14:0] V_MEMADR = 15'b0000000_1_10_00_010;
  localparam logic [14:0] V_MEMRD  = 15'b0100000_0_00_00_010;
  localparam logic [14:0] V_MEMWB  = 15'b0000011_0_00_00_010;
  localparam logic [14:0] V_MEMWR  = 15'b0110000_0_00_00_010;
  localparam logic [14:0] V_RTEX0  = 15'b0000000_1_00_00_000;
  localparam logic [14:0] V_RTWB   = 15'b0000101_0_00_00_010;
  localparam logic [14:0] V_BEQ0   = 15'b0000000_1_00_01_110;
  localparam logic [14:0] V_ADDIWB = 15'b0000001_0_00_00_010;
  localparam logic [14:0] V_JEX    = 15'b1000000_0_00_10_010;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  task automatic test_reset();
    op = LW; funct = 6'b100000; zero = 1'b0; reset_n = 1'b0;
    #12;
    compared++;
    if (state !== 4'd0 || outs !== V_RST) begin
      mismatched++;
      $display("FAIL reset_hold: state=%0d outs=%b, expected state=0 outs=%b", state, outs, V_RST);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    compared++;
    if (state !== 4'd0 || outs !== V_FETCH) begin
      mismatched++;
      $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=%b", state, outs, V_FETCH);
    end
    op = BAD;
    @(negedge clk); #1;
    compared++;
    if (state !== 4'd1 || outs !== V_DECODE) begin
      mismatched++;
      $display("FAIL first_fetch: state=%0d outs=%b, expected state=1 outs=%b", state, outs, V_DECODE);
    end
    @(negedge clk);
  endtask

  // zero held high and op scrambled after MEMADR: neither may disturb lw.
  task automatic test_lw();
    logic [5:0]  ops [6];
    logic [3:0]  st  [6];
    logic [14:0] ov  [6];
    ops = '{LW, LW, LW, BAD, SW, LW};
    st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ov  = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
    zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = ops[i]; #1;
      compared++;
      if (state !== st[i] || outs !== ov[i]) begin
        mismatched++;
        $display("FAIL lw step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, st[i], ov[i]);
      end
      if (i < 5) @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [6];
    logic [2:0]  ac  [6];
    logic [3:0]  st  [5];
    logic [14:0] ov  [5];
    fn = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000};
    ac = '{3'b111, 3'b010, 3'b110, 3'b000, 3'b001, 3'b000};
    st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    for (int k = 0; k < 6; k++) begin
      ov = '{V_FETCH, V_DECODE, V_RTEX0 | {12'd0, ac[k]}, V_RTWB, V_FETCH};
      op = RT;
      for (int i = 0; i < 5; i++) begin
        funct = (i >= 3) ? ~fn[k] : fn[k]; #1;
        compared++;
        if (state !== st[i] || outs !== ov[i]) begin
          mismatched++;
          $display("FAIL rtype funct=%b step %0d: state=%0d outs=%b, expected state=%0d outs=%b",
                   fn[k], i, state, outs, st[i], ov[i]);
        end
        if (i < 4) @(negedge clk);
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0]  st [4];
    logic [14:0] ov [4];
    st = '{4'd0, 4'd1, 4'd8, 4'd0};
    for (int z = 1; z >= 0; z--) begin
      ov = '{V_FETCH, V_DECODE, V_BEQ0 | {z[0], 14'd0}, V_FETCH};
      op = BEQ;
      for (int i = 0; i < 4; i++) begin
        zero = (i == 2) ? z[0] : 1'b1; #1;
        compared++;
        if (state !== st[i] || outs !== ov[i]) begin
          mismatched++;
          $display("FAIL beq zero=%0d step %0d: state=%0d outs=%b, expected state=%0d outs=%b",
                   z, i, state, outs, st[i], ov[i]);
        end
        if (i < 3) @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [5:0]  ops [5];
    logic [3:0]  st  [5];
    logic [14:0] ov  [5];
    ops = '{ADDI, ADDI, LW, LW, ADDI};
    st  = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    ov  = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB, V_FETCH};
    for (int i = 0; i < 5; i++) begin
      op = ops[i]; #1;
      compared++;
      if (state !== st[i] || outs !== ov[i]) begin
        mismatched++;
        $display("FAIL addi step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, st[i], ov[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [10];
    logic [3:0]  st  [10];
    logic [14:0] ov  [10];
    ops = '{SW, SW, SW, SW, JMP, JMP, JMP, BAD, BAD, LW};
    st  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd11, 4'd0, 4'd1, 4'd0};
    ov  = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH, V_DECODE, V_JEX,
            V_FETCH, V_DECODE, V_FETCH};
    for (int i = 0; i < 10; i++) begin
      op = ops[i]; #1;
      compared++;
      if (state !== st[i] || outs !== ov[i]) begin
        mismatched++;
        $display("FAIL sw_j_bad step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, st[i], ov[i]);
      end
      if (i < 9) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    op = LW;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    compared++;
    if (state !== 4'd4 || regwrite !== 1'b1) begin
      mismatched++;
      $display("FAIL areset_setup: state=%0d regwrite=%b, expected state=4 regwrite=1", state, regwrite);
    end
    #1 reset_n = 1'b0;
    #1;
    compared++;
    if (state !== 4'd0 || regwrite !== 1'b0 || outs !== V_RST) begin
      mismatched++;
      $display("FAIL areset_immediate: state=%0d outs=%b, expected state=0 outs=%b", state, outs, V_RST);
    end
    @(negedge clk); #1;
    compared++;
    if (state !== 4'd0 || outs !== V_RST) begin
      mismatched++;
      $display("FAIL areset_held: state=%0d outs=%b, expected state=0 outs=%b", state, outs, V_RST);
    end
    reset_n = 1'b1; op = BAD; #1;
    compared++;
    if (state !== 4'd0 || outs !== V_FETCH) begin
      mismatched++;
      $display("FAIL areset_release: state=%0d outs=%b, expected state=0 outs=%b", state, outs, V_FETCH);
    end
    @(negedge clk); #1;
    compared++;
    if (state !== 4'd1 || outs !== V_DECODE) begin
      mismatched++;
      $display("FAIL areset_resume: state=%0d outs=%b, expected state=1 outs=%b", state, outs, V_DECODE);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
